// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC1/PC2 tables, shift schedule, widths,
// sequencer state encoding and the 28-bit half rotation helper.
package des_pkg;

    localparam int KEY_W      = 64;
    localparam int CD_W       = 56;
    localparam int SUBKEY_W   = 48;
    localparam int HALF_W     = 28;
    localparam int NUM_ROUNDS = 16;

    // Entries are DES bit numbers (1 = MSB) of the source vector.
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_TAB [NUM_ROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [HALF_W-1:0] rot_half(
        input logic [HALF_W-1:0] x,
        input logic              left,
        input logic              by_two
    );
        logic [HALF_W-1:0] r;
        if (left) begin
            r = by_two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
        end else begin
            r = by_two ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_key_perm.sv
// Combinational DES key permutations: PC1 split into C/D halves, PC2 of the
// current C/D registers, and the odd-parity check of every key byte.
module des_key_perm
    import des_pkg::*;
(
    input  logic [KEY_W-1:0]    key_i,
    input  logic [HALF_W-1:0]   c_i,
    input  logic [HALF_W-1:0]   d_i,
    output logic [HALF_W-1:0]   pc1_c_o,
    output logic [HALF_W-1:0]   pc1_d_o,
    output logic [SUBKEY_W-1:0] subkey_o,
    output logic                par_ok_o
);

    logic [CD_W-1:0] pc1_w;
    logic [CD_W-1:0] cd_w;
    logic [7:0]      byte_odd_w;

    assign cd_w = {c_i, d_i};

    // DES bit n (1 = MSB) of a W-bit vector lives at index W-n.
    for (genvar gi = 0; gi < CD_W; gi++) begin : g_pc1
        assign pc1_w[CD_W-1-gi] = key_i[KEY_W-PC1_TAB[gi]];
    end

    for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
        assign subkey_o[SUBKEY_W-1-gi] = cd_w[CD_W-PC2_TAB[gi]];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
        assign byte_odd_w[gi] = ^key_i[8*gi +: 8];
    end

    assign pc1_c_o  = pc1_w[CD_W-1:HALF_W];
    assign pc1_d_o  = pc1_w[HALF_W-1:0];
    assign par_ok_o = &byte_odd_w;

endmodule

// File: rtl/des_key_sequencer.sv
// Streams the 16 DES round subkeys of an accepted key in encrypt (K1..K16)
// or decrypt (K16..K1) order over a valid/ready handshake.
module des_key_sequencer
    import des_pkg::*;
#(
    parameter int PARITY_CHECK = 1,
    parameter int ROUNDS       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_W-1:0]    key,
    input  logic                mode,
    input  logic                abort,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_idx,
    output logic                subkey_last,
    output logic                parity_err,
    output logic                busy
);

    if (ROUNDS != NUM_ROUNDS) begin : g_rounds_check
        $error("des_key_sequencer: ROUNDS must be 16");
    end

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              parity_err_q, parity_err_d;

    logic [HALF_W-1:0] pc1_c_w;
    logic [HALF_W-1:0] pc1_d_w;
    logic              par_ok_w;
    logic [3:0]        shift_idx_w;
    logic              by_two_w;

    des_key_perm u_perm (
        .key_i    (key),
        .c_i      (c_q),
        .d_i      (d_q),
        .pc1_c_o  (pc1_c_w),
        .pc1_d_o  (pc1_d_w),
        .subkey_o (subkey),
        .par_ok_o (par_ok_w)
    );

    // Encrypt steps forward to round cnt+2; decrypt undoes round 16-cnt.
    assign shift_idx_w = mode_q ? (4'd15 - cnt_q) : (cnt_q + 4'd1);
    assign by_two_w    = (SHIFT_TAB[shift_idx_w] == 2);

    assign busy         = (state_q == ST_RUN);
    assign subkey_valid = (state_q == ST_RUN);
    assign key_ready    = (state_q == ST_IDLE) && !abort && !rst;
    assign subkey_idx   = mode_q ? (4'd15 - cnt_q) : cnt_q;
    assign subkey_last  = (cnt_q == 4'd15);
    assign parity_err   = parity_err_q;

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        d_d          = d_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        parity_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid && key_ready) begin
                    if ((PARITY_CHECK != 0) && !par_ok_w) begin
                        parity_err_d = 1'b1;
                    end else begin
                        // Unrotated PC1 halves already equal C16/D16.
                        mode_d  = mode;
                        c_d     = mode ? pc1_c_w : rot_half(pc1_c_w, 1'b1, 1'b0);
                        d_d     = mode ? pc1_d_w : rot_half(pc1_d_w, 1'b1, 1'b0);
                        cnt_d   = 4'd0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (subkey_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        c_d   = rot_half(c_q, !mode_q, by_two_w);
                        d_d   = rot_half(d_q, !mode_q, by_two_w);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            c_q          <= '0;
            d_q          <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            d_q          <= d_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            parity_err_q <= parity_err_d;
        end
    end

endmodule

// File: tb/tb_des_key_sequencer.sv
// Bench for des_key_sequencer: two instances (parity checked / ignored) share
// the stimulus and are compared every cycle against a DES key-schedule model.
module tb_des_key_sequencer;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [63:0] key = '0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        subkey_ready = 1'b1;

    logic        key_ready_w    [2];
    logic        subkey_valid_w [2];
    logic [47:0] subkey_w       [2];
    logic [3:0]  subkey_idx_w   [2];
    logic        subkey_last_w  [2];
    logic        parity_err_w   [2];
    logic        busy_w         [2];

    int nchecks = 0;
    int nerr    = 0;

    exp_t        exp_q [2][$];
    logic        perr_exp   [2];
    logic        prev_stall [2];
    exp_t        prev_out   [2];

    always #5 clk = ~clk;

    // Instance 0 rejects bad parity, instance 1 ignores parity bits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        des_key_sequencer #(
            .PARITY_CHECK (gi == 0 ? 1 : 0),
            .ROUNDS       (16)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .key_valid    (key_valid),
            .key_ready    (key_ready_w[gi]),
            .key          (key),
            .mode         (mode),
            .abort        (abort),
            .subkey_valid (subkey_valid_w[gi]),
            .subkey_ready (subkey_ready),
            .subkey       (subkey_w[gi]),
            .subkey_idx   (subkey_idx_w[gi]),
            .subkey_last  (subkey_last_w[gi]),
            .parity_err   (parity_err_w[gi]),
            .busy         (busy_w[gi])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Round subkey Kr straight from the textbook schedule.
    function automatic logic [47:0] ks(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] out;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j < r; j++) begin
            for (int s = 0; s < SCHED[j]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) out[47-i] = cd[56-PC2[i]];
        return out;
    endfunction

    function automatic bit parity_ok(input logic [63:0] k);
        bit ok = 1'b1;
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) ok = 1'b0;
        return ok;
    endfunction

    task automatic push_seq(input int m, input logic [63:0] k, input logic md);
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            e.idx  = md ? 4'(15 - n) : 4'(n);
            e.sk   = ks(k, int'(e.idx) + 1);
            e.last = (n == 15);
            exp_q[m].push_back(e);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    initial begin
        perr_exp   = '{1'b0, 1'b0};
        prev_stall = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                bit   busy_exp;
                exp_t cur;
                if (rst) begin
                    chk($sformatf("rst_key_ready[%0d]", m), 64'(key_ready_w[m]), 64'd0);
                    chk($sformatf("rst_valid[%0d]", m), 64'(subkey_valid_w[m]), 64'd0);
                    chk($sformatf("rst_busy[%0d]", m), 64'(busy_w[m]), 64'd0);
                    chk($sformatf("rst_perr[%0d]", m), 64'(parity_err_w[m]), 64'd0);
                    exp_q[m].delete();
                    perr_exp[m]   = 1'b0;
                    prev_stall[m] = 1'b0;
                end else begin
                    busy_exp = (exp_q[m].size() != 0);
                    chk($sformatf("busy[%0d]", m), 64'(busy_w[m]), 64'(busy_exp));
                    chk($sformatf("valid[%0d]", m), 64'(subkey_valid_w[m]), 64'(busy_exp));
                    chk($sformatf("perr[%0d]", m), 64'(parity_err_w[m]), 64'(perr_exp[m]));
                    chk($sformatf("key_ready[%0d]", m), 64'(key_ready_w[m]), 64'(!busy_exp && !abort));
                    cur = '{sk: subkey_w[m], idx: subkey_idx_w[m], last: subkey_last_w[m]};
                    if (busy_exp) begin
                        chk($sformatf("subkey[%0d]", m), 64'(cur.sk), 64'(exp_q[m][0].sk));
                        chk($sformatf("idx[%0d]", m), 64'(cur.idx), 64'(exp_q[m][0].idx));
                        chk($sformatf("last[%0d]", m), 64'(cur.last), 64'(exp_q[m][0].last));
                    end
                    if (prev_stall[m] && busy_exp)
                        chk($sformatf("stall_stable[%0d]", m), 64'(cur), 64'(prev_out[m]));
                    prev_stall[m] = busy_exp && !subkey_ready && !abort;
                    prev_out[m]   = cur;
                    perr_exp[m]   = 1'b0;
                    if (busy_exp) begin
                        if (abort) exp_q[m].delete();
                        else if (subkey_ready) void'(exp_q[m].pop_front());
                    end else if (key_valid && !abort) begin
                        if (m == 0 && !parity_ok(key)) perr_exp[m] = 1'b1;
                        else push_seq(m, key, mode);
                    end
                end
            end
        end
    end

    task automatic send_key(input logic [63:0] k, input logic md);
        key_valid = 1'b1;
        key       = k;
        mode      = md;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n < budget), 64'd1);
    endtask

    // Encrypt KEY_A with ready held high; pins first and last subkey.
    task automatic run_encrypt_literal(input string tag);
        subkey_ready = 1'b1;
        send_key(KEY_A, 1'b0);
        #1;
        chk({tag, "_first"}, 64'(subkey_w[0]), 64'(K1_A));
        chk({tag, "_first_idx"}, 64'(subkey_idx_w[0]), 64'd0);
        repeat (15) @(posedge clk);
        #2;
        chk({tag, "_last"}, 64'(subkey_w[0]), 64'(K16_A));
        chk({tag, "_last_idx"}, 64'(subkey_idx_w[0]), 64'd15);
        chk({tag, "_last_flag"}, 64'(subkey_last_w[0]), 64'd1);
        wait_idle({tag, "_idle"}, 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_K1", 64'(ks(KEY_A, 1)), 64'(K1_A));
        chk("model_K2", 64'(ks(KEY_A, 2)), 64'(K2_A));
        chk("model_K16", 64'(ks(KEY_A, 16)), 64'(K16_A));
        chk("model_zero_K7", 64'(ks(64'd0, 7)), 64'd0);
        chk("model_parity_A", 64'(parity_ok(KEY_A)), 64'd1);
        chk("model_parity_0", 64'(parity_ok(64'd0)), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_reset_key_ready", 64'(key_ready_w[0]), 64'd1);
        chk("post_reset_valid", 64'(subkey_valid_w[0]), 64'd0);

        run_encrypt_literal("enc");

        send_key(KEY_A, 1'b1);
        #1;
        chk("dec_first", 64'(subkey_w[0]), 64'(K16_A));
        chk("dec_first_idx", 64'(subkey_idx_w[0]), 64'd15);
        repeat (15) @(posedge clk);
        #2;
        chk("dec_last", 64'(subkey_w[0]), 64'(K1_A));
        chk("dec_last_idx", 64'(subkey_idx_w[0]), 64'd0);
        wait_idle("dec_idle", 40);

        send_key(64'd0, 1'b0);
        #1;
        chk("zero_perr", 64'(parity_err_w[0]), 64'd1);
        chk("zero_no_valid", 64'(subkey_valid_w[0]), 64'd0);
        chk("zero_key_ready", 64'(key_ready_w[0]), 64'd1);
        chk("zero_np_valid", 64'(subkey_valid_w[1]), 64'd1);
        chk("zero_np_subkey", 64'(subkey_w[1]), 64'd0);
        @(posedge clk);
        #2;
        chk("zero_perr_pulse", 64'(parity_err_w[0]), 64'd0);
        wait_idle("zero_idle", 40);

        // Backpressure: random ready toggling across a full encrypt run.
        subkey_ready = 1'b0;
        send_key(KEY_A, 1'b0);
        for (int n = 0; n < 400 && (busy_w[0] || busy_w[1]); n++) begin
            subkey_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk("bp_done", 64'(busy_w[0] || busy_w[1]), 64'd0);
        subkey_ready = 1'b1;

        // Abort coinciding with the transfer of idx 5.
        send_key(KEY_A, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("abort_at_idx", 64'(subkey_idx_w[0]), 64'd5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        #1;
        chk("abort_valid", 64'(subkey_valid_w[0]), 64'd0);
        chk("abort_key_ready", 64'(key_ready_w[0]), 64'd1);

        // Reset in the middle of a decrypt sequence.
        send_key(KEY_A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(subkey_valid_w[0]), 64'd0);
        chk("rst_mid_key_ready", 64'(key_ready_w[0]), 64'd1);
        #2;

        run_encrypt_literal("enc2");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
